sd_dma_master: RTL and testbench
================================

# sd_dma_master

Single-channel Wishbone bus-master DMA that moves 32-bit words between system memory and the SD FIFO filler's data port, which is mapped at FIFO_ADDR on the same Wishbone bus. It sits directly upstream/downstream of the FIFO filler on the Wishbone side.
- TX: reads memory and writes the FIFO.
- RX: reads the FIFO and writes memory.
- Flow control comes from the filler's wb_full_o / wb_empty_o flags; one word is in flight at a time.

## Interface
Parameters:
- FIFO_ADDR, 32'h00000080, Wishbone address of the filler data port
- LEN_W, 16, width of the word-count register

Ports (clock and reset first):
- wb_clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse; launches a transfer; ignored while busy_o=1
- dir_i  in  1  0 = RX (FIFO→memory), 1 = TX (memory→FIFO); sampled with start_i
- mem_adr_i  in  32  memory byte base address; bits [1:0] ignored (treated 0); sampled with start_i
- len_i  in  LEN_W  number of words to move; sampled with start_i
- abort_i  in  1  level; stops the transfer at the next word boundary
- fifo_full_i  in  1  filler wb_full_o
- fifo_empty_i  in  1  filler wb_empty_o
- wb_adr_o  out  32  master address
- wb_dat_o  out  32  master write data
- wb_dat_i  in  32  master read data
- wb_we_o, wb_cyc_o, wb_stb_o  out  1  Wishbone master controls
- wb_ack_i, wb_err_i  in  1  slave termination
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when a transfer ends for any reason
- err_o  out  1  sticky bus error; cleared by the next accepted start_i
- words_o  out  LEN_W  count of words completed in the current or last transfer

## Operation
- States:
  - IDLE
  - WAIT_SRC: TX waits for nothing; RX waits for fifo_empty_i=0
  - RD: read from memory (TX) or FIFO (RX)
  - WAIT_DST: TX waits for fifo_full_i=0; RX waits for nothing
  - WR: write to FIFO (TX) or memory (RX)
  - FIN
- Transitions:
  - IDLE→WAIT_SRC on start_i when len_i≠0. With len_i=0, go IDLE→FIN directly; no bus activity.
  - WAIT_SRC→RD when the source is ready.
  - RD→WAIT_DST on ack; the read data is latched into a 32-bit holding register.
  - WAIT_DST→WR when the destination is ready.
  - On WR ack: words_o increments. Memory address advances by 4 after each memory access; it wraps modulo 2^32.
  - WR→FIN when words_o+1 equals len, or when abort_i=1. Otherwise WR→WAIT_SRC.
- abort_i takes effect only in WAIT_SRC or WAIT_DST, or at a WR ack; it goes to FIN from there.
  - A word already read in RD is still written; it is never dropped.
  - An in-progress bus cycle always completes.
- wb_err_i in RD or WR: err_o<=1, drop cyc/stb, go to FIN. The word is not counted.
- FIN: done_o=1 for one cycle, then IDLE. busy_o=1 in every state except IDLE.
- Reset mid-transfer drops cyc/stb immediately (next edge) and returns to IDLE. No done_o is produced.

## Timing
- Reset values: wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, busy_o=0, done_o=0, err_o=0, words_o=0.
- All outputs are registered.
- cyc/stb rise on the edge entering RD or WR, and stay high until the edge on which ack or err is sampled. They are low for at least one cycle between accesses (no pipelined or burst cycles).
- wb_adr_o, wb_we_o and wb_dat_o are stable while stb=1.
- RD: we=0; wb_adr_o is mem address (TX) or FIFO_ADDR (RX).
- WR: we=1; wb_adr_o is FIFO_ADDR (TX) or mem address (RX); wb_dat_o is the holding register.
- Zero-wait-state slave (ack one cycle after stb): 6 cycles per word with flags permissive (WAIT_SRC, RD×2, WAIT_DST, WR×2).
- start_i→first wb_cyc_o=1 latency: 2 cycles.
- Final WR ack→done_o: 1 cycle.
- FIFO flags are sampled only in the WAIT states. A flag change during a bus cycle is ignored.

## Structure
- Package sd_dma_pkg holds:
  - the state enum typedef
  - DIR_RX=1'b0 and DIR_TX=1'b1
  - default FIFO_ADDR
- No sub-module; single FSM plus datapath registers (address, count, holding word).

## Test plan
- TX, len=32, base 0x1000, memory model preloaded with 0x01234567…0x3c3d3e3f, filler consumer draining every 8 sd_clk → FIFO output sequence matches memory; words_o=32; one done_o pulse; err_o=0.
- RX, len=32, base 0x2000, filler fed one word every 6 sd_clk → memory 0x2000..0x207C equals the fed sequence; no read issued while fifo_empty_i=1.
- TX with consumer stalled until fifo_full_i=1 → WAIT_DST holds with cyc=0; resumes after one drain; no word lost or duplicated.
- len=0 start → done_o pulses 2 cycles after start_i; wb_cyc_o never rises; busy_o high for exactly one cycle.
- wb_err_i on 5th memory read of TX len=10 → err_o=1, words_o=4, done_o pulse; next start_i clears err_o.
- abort_i during RX after the 3rd RD ack → that word is written; words_o=3, done_o pulse. Separately, rst mid-WR → cyc/stb=0 next cycle, busy_o=0, no done_o.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD Wishbone DMA master.
// Holds the FSM state encoding, transfer direction codes and default FIFO port address.
// No logic lives here.
package sd_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SRC,
    ST_RD,
    ST_WAIT_DST,
    ST_WR,
    ST_FIN
  } state_e;

  localparam logic DIR_RX = 1'b0;  // FIFO -> memory
  localparam logic DIR_TX = 1'b1;  // memory -> FIFO

  localparam logic [31:0] DEF_FIFO_ADDR = 32'h0000_0080;

endpackage

// File: rtl/sd_dma_master.sv
// Single-channel Wishbone master DMA between system memory and the SD FIFO filler data port.
// Latency: start to first cyc 2 cycles; 6 cycles per word with a zero-wait slave; last WR ack to done 1 cycle.
// Backpressure: waits (bus idle) on fifo_empty_i before FIFO reads and fifo_full_i before FIFO writes.
module sd_dma_master
  import sd_dma_pkg::*;
#(
  parameter logic [31:0] FIFO_ADDR = DEF_FIFO_ADDR,
  parameter int          LEN_W     = 16
) (
  input  logic             wb_clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [31:0]      mem_adr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_o
);

  state_e           state_q;
  logic             dir_q;
  logic [31:0]      mem_adr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] words_q;
  logic [31:0]      dat_q;      // holding word, driven straight onto wb_dat_o
  logic [31:0]      adr_q;
  logic             we_q;
  logic             cyc_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             abort_pend_q; // abort seen while a read word is still owed to the destination

  logic [LEN_W-1:0] words_d;
  logic [31:0]      mem_adr_d;
  logic             last_word;
  logic             src_rdy;
  logic             dst_rdy;

  assign words_d   = words_q + LEN_W'(1);
  assign mem_adr_d = mem_adr_q + 32'd4;   // wraps naturally modulo 2^32
  assign last_word = (words_d == len_q);
  assign src_rdy   = (dir_q == DIR_TX) || !fifo_empty_i;
  assign dst_rdy   = (dir_q == DIR_RX) || !fifo_full_i;

  // Transfer FSM with all bus and status outputs registered alongside the state.
  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_RX;
      mem_adr_q    <= '0;
      len_q        <= '0;
      words_q      <= '0;
      dat_q        <= '0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            dir_q        <= dir_i;
            mem_adr_q    <= mem_adr_i & ~32'h3;
            len_q        <= len_i;
            words_q      <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= (len_i == '0) ? ST_FIN : ST_WAIT_SRC;
          end
        end
        ST_WAIT_SRC: begin
          if (abort_i) begin
            state_q <= ST_FIN;
          end else if (src_rdy) begin
            state_q <= ST_RD;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= (dir_q == DIR_TX) ? mem_adr_q : FIFO_ADDR;
          end
        end
        ST_RD: begin
          if (wb_err_i) begin
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            dat_q   <= wb_dat_i;
            state_q <= ST_WAIT_DST;
            if (dir_q == DIR_TX) mem_adr_q <= mem_adr_d;
          end
        end
        ST_WAIT_DST: begin
          // The held word is always delivered; an abort here is honoured after its write.
          if (abort_i) abort_pend_q <= 1'b1;
          if (dst_rdy) begin
            state_q <= ST_WR;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= (dir_q == DIR_TX) ? FIFO_ADDR : mem_adr_q;
          end
        end
        ST_WR: begin
          if (wb_err_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            words_q <= words_d;
            if (dir_q == DIR_RX) mem_adr_q <= mem_adr_d;
            state_q <= (last_word || abort_i || abort_pend_q) ? ST_FIN : ST_WAIT_SRC;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign words_o  = words_q;

endmodule

// File: tb/tb_sd_dma_master.sv
// Bench for sd_dma_master: Wishbone slave with memory and a small filler FIFO model.
// Expected bus writes and done results are queued when stimulus is issued; a monitor pops and compares.
// Producer/consumer pacing on the FIFO side creates full/empty backpressure.
module tb_sd_dma_master;

  localparam logic [31:0] FIFO_A = 32'h0000_0080;
  localparam int          DEPTH  = 4;

  logic        wb_clk = 1'b0;
  logic        rst, start_i, dir_i, abort_i;
  logic [31:0] mem_adr_i;
  logic [15:0] len_i;
  logic        fifo_full_i, fifo_empty_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_o;

  always #5 wb_clk = ~wb_clk;

  sd_dma_master dut (
    .wb_clk(wb_clk), .rst(rst), .start_i(start_i), .dir_i(dir_i),
    .mem_adr_i(mem_adr_i), .len_i(len_i), .abort_i(abort_i),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] fifo_q[$];
  logic [31:0] exp_wr_adr[$];
  logic [31:0] exp_wr_dat[$];
  logic [16:0] exp_done[$];      // {err, words}
  logic [31:0] fed_q[$];

  int          tick = 0;
  int          cons_period = 0;
  int          feed_period = 0;
  int          feed_idx = 0, feed_first = 0, feed_goal = 0, exp_lim = 0;
  logic [31:0] feed_base = '0;
  int          err_at = 0;
  int          mem_rd_cnt = 0, fifo_rd_cnt = 0;
  int          done_cnt = 0, wr_seen = 0, cyc_rise_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Wishbone slave (ack one cycle after stb), memory, FIFO model, consumer and producer.
  initial begin
    logic [31:0] d;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    fifo_full_i = 1'b0; fifo_empty_i = 1'b1;
    forever begin
      @(negedge wb_clk);
      tick++;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        if (wb_adr_o == FIFO_A) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            chk("fifo_wr_not_full", fifo_q.size() < DEPTH, 1);
            fifo_q.push_back(wb_dat_o);
          end else begin
            chk("fifo_rd_not_empty", fifo_q.size() > 0, 1);
            fifo_rd_cnt++;
            wb_dat_i = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEAD_BEEF;
          end
        end else if (!wb_we_o) begin
          mem_rd_cnt++;
          if (err_at != 0 && mem_rd_cnt == err_at) wb_err_i = 1'b1;
          else begin
            wb_ack_i = 1'b1;
            wb_dat_i = mem_rd(wb_adr_o);
          end
        end else begin
          wb_ack_i = 1'b1;
          mem[wb_adr_o] = wb_dat_o;
        end
      end
      if (cons_period > 0 && (tick % cons_period) == 0 && fifo_q.size() > 0)
        void'(fifo_q.pop_front());
      if (feed_period > 0 && feed_idx < feed_goal && (tick % feed_period) == 0 && fifo_q.size() < DEPTH) begin
        d = $urandom;
        fifo_q.push_back(d);
        if (feed_idx - feed_first < exp_lim) begin
          exp_wr_adr.push_back(feed_base + 32'(4 * (feed_idx - feed_first)));
          exp_wr_dat.push_back(d);
          fed_q.push_back(d);
        end
        feed_idx++;
      end
      fifo_full_i  = (fifo_q.size() >= DEPTH);
      fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  // Monitor: compares completed writes and done pulses against the queued expectations.
  initial begin
    logic        prev_stb, prev_cyc, prev_we;
    logic [31:0] prev_adr, prev_dat;
    logic [16:0] e;
    prev_stb = 1'b0; prev_cyc = 1'b0; prev_we = 1'b0; prev_adr = '0; prev_dat = '0;
    forever begin
      @(negedge wb_clk);
      #1;
      if (!rst) begin
        if (wb_cyc_o || wb_stb_o) chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
        if (wb_cyc_o && !prev_cyc) cyc_rise_cnt++;
        if (wb_stb_o && prev_stb) begin
          chk("stable_adr", wb_adr_o, prev_adr);
          chk("stable_we", wb_we_o, prev_we);
          if (wb_we_o) chk("stable_dat", wb_dat_o, prev_dat);
        end
        if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) begin
          wr_seen++;
          if (exp_wr_adr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            chk("wr_adr", wb_adr_o, exp_wr_adr.pop_front());
            chk("wr_dat", wb_dat_o, exp_wr_dat.pop_front());
          end
        end
        if (done_o) begin
          done_cnt++;
          if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = exp_done.pop_front();
            chk("done_words", words_o, e[15:0]);
            chk("done_err", err_o, e[16]);
          end
        end
      end
      prev_stb = wb_stb_o; prev_cyc = wb_cyc_o; prev_we = wb_we_o;
      prev_adr = wb_adr_o; prev_dat = wb_dat_o;
    end
  end

  task automatic do_start(input logic d, input logic [31:0] base, input logic [15:0] len);
    @(negedge wb_clk);
    start_i = 1'b1; dir_i = d; mem_adr_i = base; len_i = len;
    @(negedge wb_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge wb_clk);
      n++;
    end
    chk(name, done_cnt != d0, 1);
  endtask

  task automatic push_tx_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_wr_adr.push_back(FIFO_A);
      exp_wr_dat.push_back(mem_rd({base[31:2], 2'b00} + 32'(4 * i)));
    end
  endtask

  task automatic rx_arm(input logic [31:0] base, input int len, input int period, input int lim);
    fed_q.delete();
    feed_base  = {base[31:2], 2'b00};
    exp_lim    = lim;
    feed_first = feed_idx;
    feed_goal  = feed_idx + len;
    feed_period = period;
  endtask

  task automatic rx_mem_chk(input int n);
    chk("rx_fed_count", fed_q.size() >= n, 1);
    for (int i = 0; i < n && i < fed_q.size(); i++)
      chk("rx_mem", mem_rd(feed_base + 32'(4 * i)), fed_q[i]);
  endtask

  task automatic settle();
    repeat (12) @(negedge wb_clk);
    chk("leftover_exp", exp_wr_adr.size() + exp_done.size(), 0);
    cons_period = 0;
    feed_period = 0;
    feed_goal   = feed_idx;
    fifo_q.delete();
  endtask

  task automatic tx_run(input logic [31:0] base, input int len, input int period);
    int d0 = done_cnt;
    push_tx_exp(base, len);
    exp_done.push_back({1'b0, 16'(len)});
    cons_period = period;
    do_start(1'b1, base, 16'(len));
    wait_done(d0, "tx_timeout");
    settle();
  endtask

  task automatic rx_run(input logic [31:0] base, input int len, input int period);
    int d0 = done_cnt;
    exp_done.push_back({1'b0, 16'(len)});
    rx_arm(base, len, period, len);
    do_start(1'b0, base, 16'(len));
    wait_done(d0, "rx_timeout");
    rx_mem_chk(len);
    settle();
  endtask

  initial begin
    int d0, c0, w0, r0, n;
    logic [31:0] base;
    rst = 1'b1; start_i = 1'b0; dir_i = 1'b0; abort_i = 1'b0; mem_adr_i = '0; len_i = '0;
    repeat (3) @(negedge wb_clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_words", words_o, 0);
    rst = 1'b0;

    // TX 32 words from 0x1000, consumer drains every 8 cycles; also start-to-cyc latency.
    for (int i = 0; i < 32; i++) mem[32'h1000 + 32'(4 * i)] = $urandom;
    d0 = done_cnt;
    push_tx_exp(32'h1000, 32);
    exp_done.push_back({1'b0, 16'd32});
    cons_period = 8;
    do_start(1'b1, 32'h1000, 16'd32);
    chk("lat_busy", busy_o, 1);
    chk("lat_cyc_early", wb_cyc_o, 0);
    @(negedge wb_clk);
    chk("lat_cyc", wb_cyc_o, 1);
    wait_done(d0, "tx32_timeout");
    settle();

    // RX 32 words into 0x2000, producer every 6 cycles.
    rx_run(32'h2000, 32, 6);

    // TX with the consumer stalled: DMA must park in WAIT_DST with the bus idle.
    d0 = done_cnt;
    push_tx_exp(32'h3000, 8);
    exp_done.push_back({1'b0, 16'd8});
    do_start(1'b1, 32'h3000, 16'd8);
    n = 0;
    while (!fifo_full_i && n < 500) begin @(negedge wb_clk); n++; end
    repeat (10) @(negedge wb_clk);
    chk("stall_full", fifo_full_i, 1);
    chk("stall_cyc", wb_cyc_o, 0);
    chk("stall_busy", busy_o, 1);
    chk("stall_words", words_o, DEPTH);
    cons_period = 3;
    wait_done(d0, "stall_timeout");
    settle();

    // len=0: done two cycles after start, one busy cycle, no bus activity.
    c0 = cyc_rise_cnt;
    exp_done.push_back({1'b0, 16'd0});
    do_start(1'b1, 32'h4000, 16'd0);
    chk("len0_busy1", busy_o, 1);
    chk("len0_done1", done_o, 0);
    @(negedge wb_clk);
    chk("len0_busy2", busy_o, 0);
    chk("len0_done2", done_o, 1);
    @(negedge wb_clk);
    chk("len0_done3", done_o, 0);
    chk("len0_no_cyc", cyc_rise_cnt, c0);
    settle();

    // Bus error on the 5th memory read of a 10-word TX.
    d0 = done_cnt;
    err_at = mem_rd_cnt + 5;
    push_tx_exp(32'h4000, 4);
    exp_done.push_back({1'b1, 16'd4});
    cons_period = 2;
    do_start(1'b1, 32'h4000, 16'd10);
    wait_done(d0, "err_timeout");
    err_at = 0;
    settle();
    chk("err_sticky", err_o, 1);
    exp_done.push_back({1'b0, 16'd0});
    do_start(1'b1, 32'h4000, 16'd0);
    chk("err_cleared", err_o, 0);
    settle();

    // Abort during RX after the 3rd FIFO read ack: that word is still written.
    d0 = done_cnt; w0 = wr_seen; r0 = fifo_rd_cnt;
    exp_done.push_back({1'b0, 16'd3});
    rx_arm(32'h5000, 10, 2, 3);
    do_start(1'b0, 32'h5000, 16'd10);
    n = 0;
    while (fifo_rd_cnt - r0 < 3 && n < 2000) begin @(negedge wb_clk); n++; end
    abort_i = 1'b1;
    wait_done(d0, "abort_timeout");
    abort_i = 1'b0;
    chk("abort_writes", wr_seen - w0, 3);
    chk("abort_reads", fifo_rd_cnt - r0, 3);
    rx_mem_chk(3);
    settle();

    // Reset in the middle of a WR cycle.
    push_tx_exp(32'h6000, 10);
    cons_period = 2;
    do_start(1'b1, 32'h6000, 16'd10);
    n = 0;
    while (!(wb_cyc_o && wb_we_o) && n < 500) begin @(negedge wb_clk); n++; end
    chk("rst_wr_reached", wb_cyc_o && wb_we_o, 1);
    rst = 1'b1;
    @(negedge wb_clk);
    chk("rstwr_cyc", wb_cyc_o, 0);
    chk("rstwr_stb", wb_stb_o, 0);
    chk("rstwr_busy", busy_o, 0);
    chk("rstwr_done", done_o, 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge wb_clk);
    chk("rstwr_no_done", done_cnt, d0);
    exp_wr_adr.delete();
    exp_wr_dat.delete();
    settle();

    // Address wrap across 2^32.
    tx_run(32'hFFFF_FFF8, 4, 2);

    // Randomised transfers checked against the queue model.
    for (int k = 0; k < 6; k++) begin
      base = 32'h0001_0000 + 32'($urandom_range(0, 4095) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) tx_run(base, $urandom_range(1, 12), $urandom_range(1, 7));
      else rx_run(base, $urandom_range(1, 12), $urandom_range(1, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
